mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between instruction fetch and load/store traffic.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_latency_timer.sv | 33 +++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// FSM states, transaction owner and the word size/sign code.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  localparam logic [3:0] CTRL_WORD = 4'b0010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-macro signals of the arbiter.
// slave: arbiter side; master: pipeline + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              iFetchReq;
  logic [ADDR_W-1:0] iFetchAddr;
  logic              oFetchGnt;
  logic              oFetchValid;
  logic [DATA_W-1:0] oInstr;
  logic              iDataReq;
  logic              iDataWe;
  logic [ADDR_W-1:0] iDataAddr;
  logic [DATA_W-1:0] iDataWdata;
  logic [3:0]        iDataCtrl;
  logic              oDataGnt;
  logic              oDataValid;
  logic [DATA_W-1:0] oDataRdata;
  logic              oMemEn;
  logic              oMemWe;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemWdata;
  logic [3:0]        oMemCtrl;
  logic [DATA_W-1:0] iMemRdata;
  logic              oStall;

  modport slave (
    input  iFetchReq, iFetchAddr,
    input  iDataReq, iDataWe, iDataAddr,
    input  iDataWdata, iDataCtrl, iMemRdata,
    output oFetchGnt, oFetchValid, oInstr,
    output oDataGnt, oDataValid, oDataRdata,
    output oMemEn, oMemWe, oMemAddr,
    output oMemWdata, oMemCtrl, oStall
  );

  modport master (
    output iFetchReq, iFetchAddr,
    output iDataReq, iDataWe, iDataAddr,
    output iDataWdata, iDataCtrl, iMemRdata,
    input  oFetchGnt, oFetchValid, oInstr,
    input  oDataGnt, oDataValid, oDataRdata,
    input  oMemEn, oMemWe, oMemAddr,
    input  oMemWdata, oMemCtrl, oStall
  );

endinterface

// File: rtl/mem_latency_timer.sv
// Load/decrement counter that times the fixed memory latency.
// Ports: clk, rst (sync, high), load, dec, zero flag.
module mem_latency_timer #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CW'(MEM_LATENCY - 1);
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one single-ported memory.
// Ports: iClk, iRst (sync, high), bus (slave modport).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               iClk,
  input logic               iRst,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              fvalid_q, fvalid_d;
  logic              dvalid_q, dvalid_d;
  logic [SW-1:0]     streak_q, streak_d;

  logic fetch_gnt;
  logic data_gnt;
  logic fetch_wins;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;

  mem_latency_timer #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_tmr (
    .clk (iClk),
    .rst (iRst),
    .load(tmr_load),
    .dec (tmr_dec),
    .zero(tmr_zero)
  );

  // Data normally wins; a fetch starved for STARVE_LIMIT
  // consecutive data grants gets the next slot.
  assign fetch_wins = bus.iFetchReq &
    (~bus.iDataReq | (streak_q == SW'(STARVE_LIMIT)));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    ctrl_d      = ctrl_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    instr_d     = instr_q;
    drdata_d    = drdata_q;
    fvalid_d    = 1'b0;
    dvalid_d    = 1'b0;
    streak_d    = streak_q;
    fetch_gnt   = 1'b0;
    data_gnt    = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.iFetchReq | bus.iDataReq) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (fetch_wins) begin
            fetch_gnt = 1'b1;
            owner_d   = OWN_FETCH;
            we_d      = 1'b0;
            addr_d    = bus.iFetchAddr & ~ADDR_W'(3);
            ctrl_d    = CTRL_WORD;
            streak_d  = '0;
          end else begin
            data_gnt    = 1'b1;
            owner_d     = OWN_DATA;
            we_d        = bus.iDataWe;
            addr_d      = bus.iDataAddr;
            ctrl_d      = bus.iDataCtrl;
            mem_we_d    = bus.iDataWe;
            mem_wdata_d = bus.iDataWdata;
            streak_d    = bus.iFetchReq ?
                          streak_q + SW'(1) : '0;
          end
        end
      end
      ISSUE: begin
        tmr_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tmr_zero) begin
          state_d = RESP;
          if (owner_q == OWN_FETCH) begin
            instr_d  = bus.iMemRdata;
            fvalid_d = 1'b1;
          end else begin
            if (!we_q) drdata_d = bus.iMemRdata;
            dvalid_d = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      we_q        <= 1'b0;
      addr_q      <= '0;
      ctrl_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      drdata_q    <= '0;
      fvalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      ctrl_q      <= ctrl_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      drdata_q    <= drdata_d;
      fvalid_q    <= fvalid_d;
      dvalid_q    <= dvalid_d;
      streak_q    <= streak_d;
    end
  end

  assign bus.oFetchGnt   = fetch_gnt;
  assign bus.oDataGnt    = data_gnt;
  assign bus.oFetchValid = fvalid_q;
  assign bus.oDataValid  = dvalid_q;
  assign bus.oInstr      = instr_q;
  assign bus.oDataRdata  = drdata_q;
  assign bus.oMemEn      = mem_en_q;
  assign bus.oMemWe      = mem_we_q;
  assign bus.oMemAddr    = addr_q;
  assign bus.oMemWdata   = mem_wdata_q;
  assign bus.oMemCtrl    = ctrl_q;
  assign bus.oStall      = bus.iFetchReq & ~fvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, scoreboard, corner sequences.
// Two instances: MEM_LATENCY=2 (u0) and MEM_LATENCY=1 (u1).
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int L0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LATENCY(L0), .STARVE_LIMIT(4)
  ) u0 (.iClk(clk), .iRst(rst), .bus(b0));

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .MEM_LATENCY(1), .STARVE_LIMIT(4)
  ) u1 (.iClk(clk), .iRst(rst), .bus(b1));

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h104) return 32'h00A00093;
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  // Memory models: read data valid only in cycle en+L, junk otherwise.
  logic [31:0] p0a, p0b, p1a;
  always @(posedge clk) begin
    p0a <= b0.oMemEn ? mem_rd(b0.oMemAddr) : (32'hBAD00000 ^ cyc);
    p0b <= p0a;
    p1a <= b1.oMemEn ? mem_rd(b1.oMemAddr) : (32'hBAD00000 ^ cyc);
  end
  assign b0.iMemRdata = p0b;
  assign b1.iMemRdata = p1a;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  ctrl;
    int          gc;
  } txn_t;

  txn_t issue_q[$];
  txn_t resp_q[$];
  bit   gnt_log[$];
  logic [31:0] last_load = '0;
  int          last_fv_cyc = 0;
  logic [31:0] last_instr = '0;
  int          last_dv_cyc = 0;
  logic [31:0] last_drdata = '0;
  logic [31:0] last_st_wdata = '0;

  // Scoreboard for u0: push on grant, check mem issue, pop on valid.
  always @(negedge clk) begin
    if (!rst) begin
      txn_t t;
      check("gnt_excl", 64'(b0.oFetchGnt & b0.oDataGnt), 0);
      if (b0.oFetchGnt || b0.oDataGnt) begin
        t.fetch = b0.oFetchGnt;
        t.we    = b0.oFetchGnt ? 1'b0 : b0.iDataWe;
        t.addr  = b0.oFetchGnt ?
                  {b0.iFetchAddr[31:2], 2'b00} : b0.iDataAddr;
        t.wdata = b0.iDataWdata;
        t.ctrl  = b0.oFetchGnt ? CTRL_WORD : b0.iDataCtrl;
        t.rdata = mem_rd(t.addr);
        t.gc    = cyc;
        issue_q.push_back(t);
        resp_q.push_back(t);
        gnt_log.push_back(t.fetch);
      end
      if (b0.oMemEn) begin
        if (issue_q.size() == 0) flag("issue_unexpected");
        else begin
          t = issue_q.pop_front();
          check("issue_cyc", 64'(cyc - t.gc), 1);
          check("issue_addr", 64'(b0.oMemAddr), 64'(t.addr));
          check("issue_we", 64'(b0.oMemWe), 64'(t.we));
          check("issue_ctrl", 64'(b0.oMemCtrl), 64'(t.ctrl));
          if (t.we) begin
            check("issue_wdata", 64'(b0.oMemWdata), 64'(t.wdata));
            last_st_wdata = b0.oMemWdata;
          end
        end
      end else if (b0.oMemWe || b0.oMemWdata != 0) begin
        flag("mem_idle_not_quiet");
      end
      if (b0.oFetchValid || b0.oDataValid) begin
        if (resp_q.size() == 0) flag("valid_unexpected");
        else begin
          t = resp_q.pop_front();
          check("valid_owner",
                64'({b0.oFetchValid, b0.oDataValid}),
                t.fetch ? 64'd2 : 64'd1);
          check("valid_lat", 64'(cyc - t.gc), 64'(L0 + 2));
          if (t.fetch) begin
            check("instr", 64'(b0.oInstr), 64'(t.rdata));
            last_fv_cyc = cyc;
            last_instr  = b0.oInstr;
          end else begin
            if (t.we) begin
              check("store_rdata_hold", 64'(b0.oDataRdata),
                    64'(last_load));
            end else begin
              check("load_rdata", 64'(b0.oDataRdata), 64'(t.rdata));
              last_load = t.rdata;
            end
            last_dv_cyc = cyc;
            last_drdata = b0.oDataRdata;
          end
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int gc);
    gc = -1;
    b0.iFetchAddr = a;
    b0.iFetchReq  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (b0.oFetchGnt) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) flag("fetch_gnt_timeout");
    @(posedge clk);
    #1;
    b0.iFetchReq  = 1'b0;
    b0.iFetchAddr = $urandom;
  endtask

  task automatic do_data(input bit we, input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [3:0] ctrl, output int gc);
    gc = -1;
    b0.iDataWe    = we;
    b0.iDataAddr  = a;
    b0.iDataWdata = wd;
    b0.iDataCtrl  = ctrl;
    b0.iDataReq   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (b0.oDataGnt) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) flag("data_gnt_timeout");
    @(posedge clk);
    #1;
    b0.iDataReq   = 1'b0;
    b0.iDataAddr  = $urandom;
    b0.iDataWdata = $urandom;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (resp_q.size() == 0 && issue_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          freq;
    logic [31:0] faddr;
    bit          dreq;
    bit          dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [3:0]  dctrl;
    bit          exp_fetch_first;
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gf, gd, cnt;
    logic [5:0] order;

    vecs[0] = '{1, 32'h104, 0, 0, 0, 0, 0, 1};
    vecs[1] = '{0, 0, 1, 0, 32'h40, 0, CTRL_WORD, 0};
    vecs[2] = '{0, 0, 1, 1, 32'h80, 32'h11223344, CTRL_WORD, 0};
    vecs[3] = '{1, 32'h10, 1, 0, 32'h20, 0, CTRL_WORD, 0};
    vecs[4] = '{1, 32'h33, 1, 1, 32'h24, 32'hCAFEF00D, 4'h1, 0};
    vecs[5] = '{0, 0, 1, 0, 32'h7, 0, 4'h4, 0};
    vecs[6] = '{1, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 1};

    {b0.iFetchReq, b0.iDataReq, b0.iDataWe} = '0;
    {b1.iFetchReq, b1.iDataReq, b1.iDataWe} = '0;
    b0.iFetchAddr = '0; b0.iDataAddr = '0;
    b0.iDataWdata = '0; b0.iDataCtrl = '0;
    b1.iFetchAddr = '0; b1.iDataAddr = '0;
    b1.iDataWdata = '0; b1.iDataCtrl = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_flags",
          64'({b0.oFetchGnt, b0.oDataGnt, b0.oFetchValid,
               b0.oDataValid, b0.oMemEn, b0.oMemWe, b0.oStall}), 0);
    check("rst_addr", 64'(b0.oMemAddr), 0);
    check("rst_wdata_ctrl", 64'({b0.oMemWdata, b0.oMemCtrl}), 0);
    check("rst_resp", 64'({b0.oInstr, b0.oDataRdata}), 0);
    @(posedge clk);
    #1;

    // vector table
    for (int i = 0; i < 7; i++) begin
      gnt_log.delete();
      fork
        begin
          if (vecs[i].freq) do_fetch(vecs[i].faddr, gf);
        end
        begin
          if (vecs[i].dreq)
            do_data(vecs[i].dwe, vecs[i].daddr, vecs[i].dwd,
                    vecs[i].dctrl, gd);
        end
      join
      drain();
      if (gnt_log.size() == 0) flag("vec_no_gnt");
      else check("vec_first_gnt", 64'(gnt_log[0]),
                 64'(vecs[i].exp_fetch_first));
    end

    // single fetch latency and data
    do_fetch(32'h104, gf);
    drain();
    check("t1_valid_lat", 64'(last_fv_cyc - gf), 4);
    check("t1_instr", 64'(last_instr), 64'h00A00093);

    // simultaneous requests: data first, fetch 5 cycles later
    fork
      do_fetch(32'h500, gf);
      do_data(1'b0, 32'h600, 0, CTRL_WORD, gd);
    join
    drain();
    check("t2_fetch_after_data", 64'(gf - gd), 5);

    // starvation guard: D,D,D,D,F,D
    gnt_log.delete();
    fork
      do_fetch(32'h300, gf);
      begin
        for (int k = 0; k < 5; k++)
          do_data(1'b0, 32'h400 + 32'(k * 4), 0, CTRL_WORD, gd);
      end
    join
    drain();
    check("t3_gnt_count", 64'(gnt_log.size()), 6);
    order = '0;
    foreach (gnt_log[j]) order = {order[4:0], gnt_log[j]};
    check("t3_gnt_order", 64'(order), 64'b000010);

    // store leaves oDataRdata untouched
    do_data(1'b0, 32'h44, 0, CTRL_WORD, gd);
    drain();
    do_data(1'b1, 32'h200, 32'hDEADBEEF, CTRL_WORD, gd);
    drain();
    check("t4_valid_lat", 64'(last_dv_cyc - gd), 4);
    check("t4_rdata_hold", 64'(last_drdata), 64'(mem_rd(32'h44)));
    check("t4_wdata", 64'(last_st_wdata), 64'hDEADBEEF);

    // reset during WAIT abandons the transaction
    do_fetch(32'h700, gf);
    @(posedge clk);
    #1;
    rst = 1'b1;
    issue_q.delete();
    resp_q.delete();
    last_load = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_outs_zero",
          64'({b0.oFetchGnt, b0.oDataGnt, b0.oFetchValid,
               b0.oDataValid, b0.oMemEn}), 0);
    check("t5_addr_zero", 64'(b0.oMemAddr), 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b0.oFetchValid || b0.oDataValid) cnt++;
    end
    check("t5_no_valid", 64'(cnt), 0);
    @(posedge clk);
    #1;

    // MEM_LATENCY=1, unaligned fetch, fetch held until valid
    b1.iFetchAddr = 32'h103;
    b1.iFetchReq  = 1'b1;
    gf = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (b1.oFetchGnt) begin
        gf = cyc;
        break;
      end
    end
    if (gf < 0) flag("t6_gnt_timeout");
    else begin
      check("t6_stall_t0", 64'(b1.oStall), 1);
      @(negedge clk);
      check("t6_en_t1", 64'({b1.oMemEn, b1.oMemWe}), 64'b10);
      check("t6_addr", 64'(b1.oMemAddr), 64'h100);
      check("t6_ctrl", 64'(b1.oMemCtrl), 64'(CTRL_WORD));
      check("t6_stall_t1", 64'(b1.oStall), 1);
      @(negedge clk);
      check("t6_stall_t2", 64'({b1.oStall, b1.oFetchValid}), 64'b10);
      @(negedge clk);
      check("t6_valid_t3", 64'({b1.oFetchValid, b1.oStall}), 64'b10);
      check("t6_instr", 64'(b1.oInstr), 64'(mem_rd(32'h100)));
      check("t6_valid_cyc", 64'(cyc - gf), 3);
    end
    @(posedge clk);
    #1;
    b1.iFetchReq = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
